multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I core: steps through fetch/decode/execute/mem/writeback.
//  Consumes Decoder control outputs (decoded from the IR it enables) plus the ALU branch result.
//  Drives IR/PC/register-file write enables, next-PC and writeback selects, and memory request handshakes.
//  Detects stalled memory via a timeout and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles a memory request may wait for ready before fatal error (>=2)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk            in   1      system clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  run            in   1      1 = execute; sampled in IDLE and at each instruction retire
//  opcode         in   7      Decoder opcode (from IR)
//  RegWrite       in   1      Decoder control
//  MemRead        in   1      Decoder control
//  MemWrite       in   1      Decoder control
//  Branch         in   1      Decoder control
//  Jump           in   1      Decoder control
//  br_taken       in   1      ALU branch comparison result, valid in EXEC
//  imem_req       out  1      instruction fetch request, held until imem_ready
//  imem_ready     in   1      fetch data valid this cycle
//  dmem_req       out  1      data access request, held until dmem_ready
//  dmem_we        out  1      1 = store (valid while dmem_req)
//  dmem_ready     in   1      data access complete this cycle
//  ir_we          out  1      load IR (1-cycle pulse)
//  pc_we          out  1      update PC (1-cycle pulse, once per retire)
//  pc_sel         out  2      00 PC+4, 01 PC+imm (branch/jal), 10 rs1+imm (jalr)
//  rf_we          out  1      register-file write (1-cycle pulse)
//  wb_sel         out  2      00 ALU, 01 load data, 10 PC+4
//  state          out  3      current FSM state (encoding below)
//  instret        out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
//  mem_err        out  1      sticky: memory timeout occurred
//  illegal_instr  out  1      sticky: illegal opcode trapped (0 unless ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; instret=0; timeout counter=0; sticky flags cleared.
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 TRAP=7. Registered state; Moore/Mealy outputs combinational from state+inputs.
//  IDLE: run=1 -> FETCH.
//  FETCH: imem_req=1; on imem_ready: ir_we=1, -> DECODE (1 cycle min).
//  DECODE: 1 cycle; Decoder inputs valid from here on -> EXEC.
//  EXEC (1 cycle): Branch: pc_we=1, pc_sel=br_taken?01:00, retire.
//   else MemRead|MemWrite -> MEM; else Jump|RegWrite -> WB; else NOP: pc_we=1 pc_sel=00, retire.
//  MEM: dmem_req=1, dmem_we=MemWrite; on dmem_ready: store -> pc_we=1 pc_sel=00 retire; load -> WB.
//  WB (1 cycle): rf_we=1; wb_sel=01 load, 10 jal/jalr, else 00; pc_we=1;
//   pc_sel=01 opcode 1101111, 10 opcode 1100111, else 00; retire.
//  Retire: instret+=1 same edge as pc_we; next state FETCH if run=1 else IDLE (run=0 never aborts mid-instruction).
//  Latency, zero-wait memory: branch/NOP 3, R/I-ALU/store/jump 4, load 5 cycles.
//  Timeout: counter clears on entry to FETCH/MEM and on ready; increments each req cycle without ready;
//   reaching MEM_TIMEOUT-1 with no ready -> HALT, mem_err=1. Ready in that same cycle wins (no error).
//  HALT/TRAP: all req/we outputs 0; left only by reset.
//  rst_n asserted mid-request: imem_req/dmem_req drop asynchronously; no write pulse produced.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: in DECODE, opcode not in {0110011,0010011,0000011,0100011,1100011,1101111,1100111}
//   -> TRAP, illegal_instr=1, no pc_we, instret unchanged.
//  Undefined: illegal opcodes follow EXEC NOP path (PC+4, retire); illegal_instr tied 0; TRAP unreachable.
// TESTING
//  run=1, imem_ready=1, opcode 0110011 RegWrite=1 -> states 1,2,3,5,1; rf_we+pc_we(sel 00) in WB; instret=1.
//  Load (MemRead=1,RegWrite=1), dmem_ready after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, wb_sel=01, 8 cycles total.
//  Branch=1 br_taken=1 -> pc_we pc_sel=01 in EXEC, no rf_we, back to FETCH after 3 cycles; br_taken=0 -> pc_sel=00.
//  jalr (opcode 1100111, Jump=1) -> WB with wb_sel=10, pc_sel=10, rf_we=1.
//  imem_ready held 0, MEM_TIMEOUT=16 -> HALT after 16 FETCH cycles, mem_err=1, imem_req=0; ready on 16th cycle -> no error.
//  opcode 0000000: macro on -> TRAP, illegal_instr=1, instret unchanged; off -> NOP retire in 3 cycles. rst_n low in MEM -> all outputs 0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction/data memory request handshake between sequencer and memories
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle fetch/decode/exec/mem/wb sequencer (optional ILLEGAL_TRAP_EN)
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [6:0]           opcode,
    input  logic                 RegWrite,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 Branch,
    input  logic                 Jump,
    input  logic                 br_taken,
    multicycle_ctrl_if.master    mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     instret,
    output logic                 mem_err,
    output logic                 illegal_instr
);
    localparam int TW = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             mem_err_q, mem_err_d;
    logic             illegal_q, illegal_d;
    logic             retire;
    logic             imem_req_c, dmem_req_c, dmem_we_c;
    logic             opcode_legal;

`ifdef ILLEGAL_TRAP_EN
    assign opcode_legal = opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                         7'b1100011, 7'b1101111, 7'b1100111};
`else
    assign opcode_legal = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        tcnt_d     = '0;
        instret_d  = instret_q;
        mem_err_d  = mem_err_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'b00;
        rf_we      = 1'b0;
        wb_sel     = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (mem.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (tcnt_q == T_LAST) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (!opcode_legal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (Branch) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? 2'b01 : 2'b00;
                    retire = 1'b1;
                end else if (MemRead || MemWrite) begin
                    state_d = S_MEM;
                end else if (Jump || RegWrite) begin
                    state_d = S_WB;
                end else begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = MemWrite;
                if (mem.dmem_ready) begin
                    if (MemWrite) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tcnt_q == T_LAST) begin
                    state_d   = S_HALT;
                    mem_err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                if (MemRead)   wb_sel = 2'b01;
                else if (Jump) wb_sel = 2'b10;
                if (opcode == 7'b1101111)      pc_sel = 2'b01;
                else if (opcode == 7'b1100111) pc_sel = 2'b10;
            end
            default: ;  // HALT and TRAP are only left through reset
        endcase

        // Retire is the only point where run is re-sampled, so run=0 never cuts an instruction short.
        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
            state_d   = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            instret_q <= '0;
            mem_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            instret_q <= instret_d;
            mem_err_q <= mem_err_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign state        = state_q;
    assign instret      = instret_q;
    assign mem_err      = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        RegWrite, MemRead, MemWrite, Branch, Jump, br_taken;
    logic        ir_we, pc_we, rf_we, mem_err, illegal_instr;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic [31:0] instret;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          req_cycles;

    multicycle_ctrl_if mem_if ();

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .Jump(Jump), .br_taken(br_taken),
        .mem(mem_if.master),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .state(state), .instret(instret), .mem_err(mem_err), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic [6:0] op, input logic rw, input logic mr, input logic mw,
                            input logic br, input logic jp, input logic bt);
        opcode = op; RegWrite = rw; MemRead = mr; MemWrite = mw;
        Branch = br; Jump = jp; br_taken = bt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0;
        mem_if.imem_ready = 1'b0; mem_if.dmem_ready = 1'b0;
        set_ctrl(7'b0000000, 0, 0, 0, 0, 0, 0);
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_imem_req", 32'(mem_if.imem_req), 32'd0);
        check("rst_dmem_req", 32'(mem_if.dmem_req), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_illegal", 32'(illegal_instr), 32'd0);

        // R-type: FETCH, DECODE, EXEC, WB
        tick();
        rst_n = 1'b1; run = 1'b1; mem_if.imem_ready = 1'b1;
        set_ctrl(7'b0110011, 1, 0, 0, 0, 0, 0);
        #1 check("r_idle", 32'(state), 32'd0);
        tick(); check("r_fetch", 32'(state), 32'd1);
        check("r_imem_req", 32'(mem_if.imem_req), 32'd1);
        check("r_ir_we", 32'(ir_we), 32'd1);
        tick(); check("r_decode", 32'(state), 32'd2);
        tick(); check("r_exec", 32'(state), 32'd3);
        check("r_exec_pc_we", 32'(pc_we), 32'd0);
        tick(); check("r_wb", 32'(state), 32'd5);
        check("r_rf_we", 32'(rf_we), 32'd1);
        check("r_pc_we", 32'(pc_we), 32'd1);
        check("r_pc_sel", 32'(pc_sel), 32'd0);
        check("r_wb_sel", 32'(wb_sel), 32'd0);
        check("r_instret_pre", instret, 32'd0);
        tick(); check("r_back_fetch", 32'(state), 32'd1);
        check("r_instret", instret, 32'd1);

        // Load with three wait cycles: dmem_req high for four cycles, eight cycles total
        set_ctrl(7'b0000011, 1, 1, 0, 0, 0, 0);
        mem_if.dmem_ready = 1'b0;
        tick(); tick(); check("ld_exec", 32'(state), 32'd3);
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) mem_if.dmem_ready = 1'b1;
            #1;
            if (mem_if.dmem_req) req_cycles++;
            if (i == 0) check("ld_dmem_we", 32'(mem_if.dmem_we), 32'd0);
        end
        check("ld_req_cycles", 32'(req_cycles), 32'd4);
        tick(); mem_if.dmem_ready = 1'b0;
        check("ld_wb", 32'(state), 32'd5);
        check("ld_wb_sel", 32'(wb_sel), 32'd1);
        check("ld_rf_we", 32'(rf_we), 32'd1);
        tick(); check("ld_fetch", 32'(state), 32'd1);
        check("ld_instret", instret, 32'd2);

        // Branch taken then not taken
        set_ctrl(7'b1100011, 0, 0, 0, 1, 0, 1);
        tick(); tick(); check("bt_exec", 32'(state), 32'd3);
        check("bt_pc_we", 32'(pc_we), 32'd1);
        check("bt_pc_sel", 32'(pc_sel), 32'd1);
        check("bt_rf_we", 32'(rf_we), 32'd0);
        tick(); check("bt_fetch", 32'(state), 32'd1);
        check("bt_instret", instret, 32'd3);
        br_taken = 1'b0;
        tick(); tick(); check("bn_pc_we", 32'(pc_we), 32'd1);
        check("bn_pc_sel", 32'(pc_sel), 32'd0);
        tick(); check("bn_instret", instret, 32'd4);

        // jalr then jal
        set_ctrl(7'b1100111, 1, 0, 0, 0, 1, 0);
        tick(); tick(); tick(); check("jalr_wb", 32'(state), 32'd5);
        check("jalr_wb_sel", 32'(wb_sel), 32'd2);
        check("jalr_pc_sel", 32'(pc_sel), 32'd2);
        check("jalr_rf_we", 32'(rf_we), 32'd1);
        tick();
        set_ctrl(7'b1101111, 1, 0, 0, 0, 1, 0);
        tick(); tick(); tick(); check("jal_pc_sel", 32'(pc_sel), 32'd1);
        check("jal_wb_sel", 32'(wb_sel), 32'd2);
        tick(); check("jal_instret", instret, 32'd6);

        // Zero-wait store retires out of MEM
        set_ctrl(7'b0100011, 0, 0, 1, 0, 0, 0);
        mem_if.dmem_ready = 1'b1;
        tick(); tick(); tick(); check("st_mem", 32'(state), 32'd4);
        check("st_dmem_req", 32'(mem_if.dmem_req), 32'd1);
        check("st_dmem_we", 32'(mem_if.dmem_we), 32'd1);
        check("st_pc_we", 32'(pc_we), 32'd1);
        check("st_rf_we", 32'(rf_we), 32'd0);
        tick(); mem_if.dmem_ready = 1'b0;
        check("st_instret", instret, 32'd7);

        // Opcode 0000000
        set_ctrl(7'b0000000, 0, 0, 0, 0, 0, 0);
        tick(); tick();
`ifdef ILLEGAL_TRAP_EN
        check("ill_trap", 32'(state), 32'd7);
        check("ill_flag", 32'(illegal_instr), 32'd1);
        check("ill_pc_we", 32'(pc_we), 32'd0);
        tick(); check("ill_instret", instret, 32'd7);
`else
        check("ill_exec", 32'(state), 32'd3);
        check("ill_pc_we", 32'(pc_we), 32'd1);
        check("ill_pc_sel", 32'(pc_sel), 32'd0);
        tick(); check("ill_fetch", 32'(state), 32'd1);
        check("ill_instret", instret, 32'd8);
        check("ill_flag", 32'(illegal_instr), 32'd0);
`endif

        // Fetch ready on the 16th wait cycle wins over timeout
        do_reset();
        set_ctrl(7'b0010011, 0, 0, 0, 0, 0, 0);
        mem_if.imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check("to16_fetch", 32'(state), 32'd1);
        mem_if.imem_ready = 1'b1;
        tick(); check("to16_decode", 32'(state), 32'd2);
        check("to16_no_err", 32'(mem_err), 32'd0);
        mem_if.imem_ready = 1'b0;
        tick(); tick(); check("to16_instret", instret, 32'd1);

        // No ready: HALT after 16 FETCH cycles
        for (int i = 0; i < 15; i++) tick();
        check("to_last_fetch", 32'(state), 32'd1);
        check("to_last_req", 32'(mem_if.imem_req), 32'd1);
        tick(); check("to_halt", 32'(state), 32'd6);
        check("to_mem_err", 32'(mem_err), 32'd1);
        check("to_imem_req", 32'(mem_if.imem_req), 32'd0);
        mem_if.imem_ready = 1'b1;
        tick(); check("to_stuck", 32'(state), 32'd6);

        // Async reset in the middle of a data request
        do_reset();
        set_ctrl(7'b0000011, 1, 1, 0, 0, 0, 0);
        mem_if.dmem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        check("ar_mem", 32'(state), 32'd4);
        check("ar_dmem_req", 32'(mem_if.dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_state", 32'(state), 32'd0);
        check("ar_dmem_req_low", 32'(mem_if.dmem_req), 32'd0);
        check("ar_rf_we", 32'(rf_we), 32'd0);
        check("ar_pc_we", 32'(pc_we), 32'd0);
        check("ar_mem_err", 32'(mem_err), 32'd0);
        check("ar_instret", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
